irq_tx: RTL and testbench



---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_fifo.sv | 43 ++++
 rtl/irq_tx.sv | 120 ++++++++++++
 tb/tb_irq_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: state encoding and interrupt word layout shared by irq_tx and its queue.
// Words are stored MSB-first ([0:15]) to match the system bus bit numbering.
package irq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ARB, S_STROBE, S_RELEASE, S_BACKOFF} state_t;
   typedef logic [0:15] irq_word_t;
   localparam int IRQ_CPU_BIT  = 15;
   localparam int IRQ_PRIO_BIT = 0;
   localparam int IRQ_CHAN_LSB = 11;
   function automatic irq_word_t irq_word(input logic cpu, input logic lo, input logic [3:0] chan);
      irq_word_t w;
      w = '0;
      if (cpu) begin
         w[IRQ_CPU_BIT]  = 1'b1;
         w[IRQ_PRIO_BIT] = lo;
      end else
         w[IRQ_CHAN_LSB +: 4] = chan;
      return w;
   endfunction
endpackage

// File: rtl/irq_fifo.sv
// irq_fifo: circular queue of pending interrupt words; caller never pushes
// into a full queue unless it pops in the same clock.
import irq_pkg::*;
module irq_fifo #(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  irq_word_t din,
   output irq_word_t head,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   irq_word_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      wr_d  = push ? wr_q + AW'(1) : wr_q;
      rd_d  = pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end
   assign head  = mem_q[rd_q];
   assign full  = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
endmodule

// File: rtl/irq_tx.sv
// irq_tx: queues interrupt words and delivers the head word on the system bus,
// strobing rin until dok, backing off and retrying on timeout.
import irq_pkg::*;
module irq_tx #(
   parameter int DEPTH       = 4,
   parameter int DOK_TIMEOUT = 16,
   parameter int RETRY_TICKS = 32,
   parameter int MAX_RETRY   = 0
) (
   input  logic        __clk,
   input  logic        clm,
   input  logic        req,
   input  logic        req_cpu,
   input  logic        req_lo,
   input  logic [3:0]  req_chan,
   output logic        full,
   output logic        pending,
   output logic        overflow,
   output logic        bus_req,
   input  logic        bus_grant,
   output logic        rin,
   output logic [0:15] dout,
   input  logic        dok,
   output logic        done,
   output logic        drop
);
   localparam int TW = $clog2(DOK_TIMEOUT);
   localparam int BW = $clog2(RETRY_TICKS + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   state_t state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic rin_q, rin_d, bus_req_q, bus_req_d, done_q, done_d, drop_q, drop_d, overflow_q, overflow_d;
   irq_word_t dout_q, dout_d, head;
   logic fifo_full, fifo_empty, push, pop, timeout, give_up, released;
   // a pop frees a slot in the same clock, so a request then is never an overflow
   assign pop  = released || give_up;
   assign push = req && (!fifo_full || pop);
   irq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (__clk),
      .rst   (clm),
      .push  (push),
      .pop   (pop),
      .din   (irq_word(req_cpu, req_lo, req_chan)),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   always_ff @(posedge __clk) begin
      if (clm) begin
         state_q    <= S_IDLE;
         tcnt_q     <= '0;
         bcnt_q     <= '0;
         retry_q    <= '0;
         rin_q      <= 1'b0;
         bus_req_q  <= 1'b0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         bcnt_q     <= bcnt_d;
         retry_q    <= retry_d;
         rin_q      <= rin_d;
         bus_req_q  <= bus_req_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end
   always_comb begin
      timeout  = state_q == S_STROBE && !dok && tcnt_q == TW'(DOK_TIMEOUT - 1);
      give_up  = timeout && MAX_RETRY != 0 && retry_q + RW'(1) == RW'(MAX_RETRY);
      released = state_q == S_RELEASE && !dok;
      state_d  = state_q;
      tcnt_d   = '0;
      bcnt_d   = '0;
      retry_d  = retry_q;
      case (state_q)
         S_IDLE:    state_d = fifo_empty ? S_IDLE : S_ARB;
         S_ARB:     state_d = bus_grant ? S_STROBE : S_ARB;
         S_STROBE: begin
            tcnt_d = tcnt_q + TW'(1);
            if (dok) begin
               state_d = S_RELEASE;
               retry_d = '0;
            end else if (timeout) begin
               state_d = give_up ? S_IDLE : S_BACKOFF;
               retry_d = (give_up || MAX_RETRY == 0) ? '0 : retry_q + RW'(1);
            end
         end
         S_RELEASE: state_d = dok ? S_RELEASE : S_IDLE;
         S_BACKOFF: begin
            bcnt_d  = bcnt_q + BW'(1);
            state_d = bcnt_q == BW'(RETRY_TICKS - 1) ? S_ARB : S_BACKOFF;
         end
         default:   state_d = S_IDLE;
      endcase
   end
   always_comb begin
      rin_d      = state_d == S_STROBE;
      bus_req_d  = state_d == S_ARB || state_d == S_STROBE;
      dout_d     = rin_d ? head : '0;
      done_d     = released;
      drop_d     = give_up;
      overflow_d = req && fifo_full && !pop;
   end
   assign full     = fifo_full;
   assign pending  = !fifo_empty;
   assign overflow = overflow_q;
   assign bus_req  = bus_req_q;
   assign rin      = rin_q;
   assign dout     = dout_q;
   assign done     = done_q;
   assign drop     = drop_q;
endmodule

// File: tb/tb_irq_tx.sv
// tb_irq_tx: scoreboard bench; requests push expected words, a negedge monitor
// checks each strobed word and pops on done/drop.
module tb_irq_tx;
   localparam int DEPTH = 4;
   logic clk = 0, clm = 1, req = 0, req_cpu = 0, req_lo = 0, bus_grant = 0;
   logic [3:0] req_chan = 0;
   logic full, pending, overflow, bus_req, rin, done, drop, dok;
   logic [0:15] dout;
   logic auto_dok = 0, dok_man = 0, dok_auto = 0;
   logic [15:0] exp_q[$];
   int n_chk = 0, n_pass = 0, n_done = 0, n_drop = 0, n_ovf = 0, n_ovf_exp = 0;
   int win_lens[$], breq_gaps[$];
   int age = 0, lat = 0, rin_len = 0, gap_len = 0;
   logic rin_p = 0, breq_p = 0;
   logic [15:0] rin_word = 0;

   irq_tx #(.DEPTH(DEPTH), .DOK_TIMEOUT(16), .RETRY_TICKS(32), .MAX_RETRY(2)) dut (
      .__clk(clk), .clm(clm), .req(req), .req_cpu(req_cpu), .req_lo(req_lo), .req_chan(req_chan),
      .full(full), .pending(pending), .overflow(overflow), .bus_req(bus_req), .bus_grant(bus_grant),
      .rin(rin), .dout(dout), .dok(dok), .done(done), .drop(drop)
   );

   always #5 clk = ~clk;
   assign dok = auto_dok ? dok_auto : dok_man;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected word from the bus layout: index 0 is the value MSB
   task automatic post(input logic cpu, input logic lo, input logic [3:0] ch, input bit pop_now);
      logic [15:0] w;
      w = cpu ? {lo, 14'b0, 1'b1} : {11'b0, ch, 1'b0};
      if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(w);
      else n_ovf_exp++;
      req = 1; req_cpu = cpu; req_lo = lo; req_chan = ch;
      tick();
      req = 0;
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || pending) && i < budget) begin
         tick();
         i++;
      end
      chk("drain", 32'(i < budget), 1);
   endtask

   task automatic wait_rin(input int budget);
      for (int i = 0; i < budget && !rin; i++) tick();
      chk("rin_rise", 32'(rin), 1);
   endtask

   // acceptor: answers each strobe after a random 0..3 clock delay with a 1-clock dok
   initial forever begin
      tick();
      if (dok_auto) dok_auto = 0;
      else if (auto_dok && rin) begin
         if (age >= lat) begin
            dok_auto = 1;
            age = 0;
            lat = $urandom_range(0, 3);
         end else age++;
      end else age = 0;
   end

   always @(negedge clk) begin
      if (rin) begin
         if (!rin_p) begin
            rin_len = 0;
            rin_word = dout;
            chk("strobe_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("strobe_word", 32'(dout), 32'(exp_q[0]));
         end else chk("dout_stable", 32'(dout), 32'(rin_word));
         rin_len++;
      end else if (rin_p) begin
         win_lens.push_back(rin_len);
         chk("dout_idle", 32'(dout), 0);
      end
      if (breq_p && !bus_req) gap_len = 0;
      if (!bus_req) gap_len++;
      if (bus_req && !breq_p) breq_gaps.push_back(gap_len);
      if (done || drop) begin
         chk("done_drop_excl", 32'(done && drop), 0);
         chk("pop_has_entry", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            chk("popped_word", 32'(rin_word), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         if (done) n_done++;
         else n_drop++;
      end
      if (overflow) n_ovf++;
      rin_p = rin;
      breq_p = bus_req;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      tick(); tick();
      chk("rst_rin", 32'(rin), 0);
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_done_drop_ovf", 32'({done, drop, overflow}), 0);
      chk("rst_full_pending", 32'({full, pending}), 0);
      clm = 0;
      // single channel interrupt, chan 5 lands in bits 12 and 14
      bus_grant = 1; auto_dok = 1; d0 = n_done;
      post(0, 0, 4'd5, 0);
      drain(100);
      chk("chan5_word", 32'(rin_word), 32'h000A);
      chk("chan5_done", 32'(n_done - d0), 1);
      chk("chan5_pending", 32'(pending), 0);
      // random mix with random grant, never beyond queue capacity
      for (int k = 0; k < 40; k++) begin
         bus_grant = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH)
            post($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 0);
         else tick();
      end
      bus_grant = 1;
      drain(1000);
      // fill without grant, fifth request overflows
      bus_grant = 0; d0 = n_done;
      for (int k = 0; k < 4; k++) post(k[0], 1, 4'(k + 8), 0);
      chk("fill_full", 32'(full), 1);
      chk("fill_pending", 32'(pending), 1);
      post(1, 0, 4'd0, 0);
      chk("ovf_pulse", 32'(overflow), 1);
      chk("ovf_full", 32'(full), 1);
      tick();
      chk("ovf_one_clock", 32'(overflow), 0);
      chk("arb_bus_req", 32'(bus_req), 1);
      chk("arb_no_rin", 32'(rin), 0);
      bus_grant = 1;
      drain(300);
      chk("fill_done_count", 32'(n_done - d0), 4);
      // dok held after acceptance, then push during the pop clock while full
      auto_dok = 0; dok_man = 0; bus_grant = 0; d0 = n_done;
      for (int k = 0; k < 4; k++) post(0, 0, 4'(k + 1), 0);
      bus_grant = 1;
      wait_rin(20);
      dok_man = 1;
      tick();
      chk("hold_rin_fall", 32'(rin), 0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("hold_no_rin", 32'(rin), 0);
         chk("hold_no_done", 32'(done), 0);
      end
      dok_man = 0;
      post(1, 1, 4'd0, 1);
      chk("pushpop_no_ovf", 32'(overflow), 0);
      chk("pushpop_full", 32'(full), 1);
      chk("pushpop_done", 32'(done), 1);
      auto_dok = 1;
      drain(300);
      chk("pushpop_done_count", 32'(n_done - d0), 5);
      // no acceptor: two strobe windows, one backoff, then drop
      auto_dok = 0; dok_man = 0; d0 = n_done;
      win_lens.delete(); breq_gaps.delete();
      begin
         int dr;
         dr = n_drop;
         post(1, 1, 4'd0, 0);
         for (int i = 0; i < 300 && n_drop == dr; i++) tick();
         tick();
         chk("drop_count", 32'(n_drop - dr), 1);
      end
      chk("drop_windows", 32'(win_lens.size()), 2);
      if (win_lens.size() == 2) begin
         chk("drop_win0_len", 32'(win_lens[0]), 16);
         chk("drop_win1_len", 32'(win_lens[1]), 16);
      end
      chk("backoff_len", 32'(breq_gaps.size() > 0 ? breq_gaps[$] : 0), 32);
      chk("drop_pending", 32'(pending), 0);
      chk("drop_no_done", 32'(n_done - d0), 0);
      // clear mid-strobe
      d0 = n_done;
      begin
         int dr;
         dr = n_drop;
         post(0, 0, 4'd9, 0);
         wait_rin(10);
         clm = 1;
         tick();
         chk("clm_rin", 32'(rin), 0);
         chk("clm_bus_req", 32'(bus_req), 0);
         chk("clm_pending", 32'(pending), 0);
         clm = 0;
         exp_q.delete();
         repeat (5) tick();
         chk("clm_no_pulse", 32'((n_done - d0) + (n_drop - dr)), 0);
      end
      auto_dok = 1;
      post(0, 0, 4'd3, 0);
      drain(100);
      chk("post_clm_done", 32'(n_done - d0), 1);
      chk("ovf_total", 32'(n_ovf), 32'(n_ovf_exp));
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
